writeback_buffer: RTL and testbench

//  Victim/write-back FIFO between CACHE and the MainBus memory port. Accepts dirty evicted

---
 rtl/writeback_buffer_pkg.sv | 32 +++
 rtl/writeback_buffer_if.sv | 52 +++++
 rtl/wb_addr_match.sv | 29 ++
 rtl/writeback_buffer.sv | 134 +++++++++++++
 tb/tb_writeback_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_buffer_pkg.sv
// Shared types and sizes for the write-back (victim) buffer.
//   WB_DEPTH   : default number of buffered blocks
//   wb_entry_t : one buffered block {valid, index, tag, data}
//   wb_state_t : drain FSM states
package writeback_buffer_pkg;

  localparam int WB_DEPTH   = 4;
  localparam int INDEXBITS  = 8;
  localparam int TAGBITS    = 6;
  localparam int BLOCKBYTES = 4;
  localparam int DATABITS   = BLOCKBYTES * 8;

  typedef struct packed {
    logic                 valid;
    logic [INDEXBITS-1:0] index;
    logic [TAGBITS-1:0]   tag;
    logic [DATABITS-1:0]  data;
  } wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  // Block address compare; byte-select bits never reach the buffer.
  function automatic logic addr_eq(input wb_entry_t e,
                                   input logic [INDEXBITS-1:0] idx,
                                   input logic [TAGBITS-1:0] tag);
    return e.valid && (e.index == idx) && (e.tag == tag);
  endfunction

endpackage

// File: rtl/writeback_buffer_if.sv
// Bundle of the cache-side, bus-side and snoop-side signals of the write-back buffer.
//   slave  : the buffer itself
//   master : the environment (cache + MainBus) driving it
interface writeback_buffer_if;
  import writeback_buffer_pkg::*;

  logic                 evict_valid;
  logic                 evict_ready;
  logic [INDEXBITS-1:0] evict_index;
  logic [TAGBITS-1:0]   evict_tag;
  logic [DATABITS-1:0]  evict_data;

  logic [INDEXBITS-1:0] lookup_index;
  logic [TAGBITS-1:0]   lookup_tag;
  logic                 lookup_hit;
  logic [DATABITS-1:0]  lookup_data;

  logic                 mem_write;
  logic [INDEXBITS-1:0] mem_index;
  logic [TAGBITS-1:0]   mem_tag;
  logic [DATABITS-1:0]  mem_data;
  logic                 bus_grant;

  logic                 snoop_busrd;
  logic                 snoop_busupd;
  logic [INDEXBITS-1:0] snoop_index;
  logic [TAGBITS-1:0]   snoop_tag;
  logic [DATABITS-1:0]  snoop_data;
  logic                 snoop_shared;
  logic [DATABITS-1:0]  snoop_flush;

  modport slave (
    input  evict_valid, evict_index, evict_tag, evict_data,
    input  lookup_index, lookup_tag,
    input  bus_grant,
    input  snoop_busrd, snoop_busupd, snoop_index, snoop_tag, snoop_data,
    output evict_ready, lookup_hit, lookup_data,
    output mem_write, mem_index, mem_tag, mem_data,
    output snoop_shared, snoop_flush
  );

  modport master (
    output evict_valid, evict_index, evict_tag, evict_data,
    output lookup_index, lookup_tag,
    output bus_grant,
    output snoop_busrd, snoop_busupd, snoop_index, snoop_tag, snoop_data,
    input  evict_ready, lookup_hit, lookup_data,
    input  mem_write, mem_index, mem_tag, mem_data,
    input  snoop_shared, snoop_flush
  );

endinterface

// File: rtl/wb_addr_match.sv
// {index,tag} CAM compare across all buffer entries.
//   i_entries : entry array
//   i_index   : address index to match
//   i_tag     : address tag to match
//   o_hit_vec : one-hot hit vector (at most one entry can match)
//   o_data    : data of the hitting entry, 0 when nothing hits
module wb_addr_match import writeback_buffer_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0] i_entries,
  input  logic [INDEXBITS-1:0]  i_index,
  input  logic [TAGBITS-1:0]    i_tag,
  output logic [DEPTH-1:0]      o_hit_vec,
  output logic [DATABITS-1:0]   o_data
);

  // Hits are one-hot, so an OR-reduction is a valid mux.
  always_comb begin
    o_hit_vec = '0;
    o_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_eq(i_entries[i], i_index, i_tag)) begin
        o_hit_vec[i] = 1'b1;
        o_data       = o_data | i_entries[i].data;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Victim/write-back FIFO between the cache and the MainBus memory port.
// Dirty evicted blocks are queued, drained to memory as bus WRITEs, and remain
// visible to snoops and cache-miss lookups until their write completes.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : evict / lookup / mem / snoop signal bundle (slave side)
//
// state | meaning
// IDLE  | buffer empty at last edge, no request on the bus
// WRITE | mem_write asserted, head entry presented until bus_grant
module writeback_buffer import writeback_buffer_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input logic              clock,
  input logic              reset,
  writeback_buffer_if.slave bus
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] r_entries;
  logic [PTRW-1:0]       r_head;
  logic [PTRW-1:0]       r_tail;
  logic [CNTW-1:0]       r_count;
  wb_state_t             r_state;

  wb_state_t             w_state_next;
  wb_entry_t             w_head;
  logic [CNTW-1:0]       w_count_next;
  logic [DEPTH-1:0]      w_ev_hit;
  logic [DEPTH-1:0]      w_sn_hit;
  logic [DEPTH-1:0]      w_lk_hit;
  logic [DEPTH-1:0]      w_ev_coal_vec;
  logic [DEPTH-1:0]      w_upd_hit;
  logic [DATABITS-1:0]   w_ev_data;
  logic [DATABITS-1:0]   w_sn_data;
  logic [DATABITS-1:0]   w_lk_data;
  logic                  w_evict_ready;
  logic                  w_evict_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_mem_write;

  wb_addr_match #(.DEPTH(DEPTH)) u_match_evict (
    .i_entries (r_entries),
    .i_index   (bus.evict_index),
    .i_tag     (bus.evict_tag),
    .o_hit_vec (w_ev_hit),
    .o_data    (w_ev_data)
  );

  wb_addr_match #(.DEPTH(DEPTH)) u_match_snoop (
    .i_entries (r_entries),
    .i_index   (bus.snoop_index),
    .i_tag     (bus.snoop_tag),
    .o_hit_vec (w_sn_hit),
    .o_data    (w_sn_data)
  );

  wb_addr_match #(.DEPTH(DEPTH)) u_match_lookup (
    .i_entries (r_entries),
    .i_index   (bus.lookup_index),
    .i_tag     (bus.lookup_tag),
    .o_hit_vec (w_lk_hit),
    .o_data    (w_lk_data)
  );

  assign w_head        = r_entries[r_head];
  assign w_evict_ready = !reset && (r_count < CNTW'(DEPTH));
  assign w_evict_fire  = bus.evict_valid && w_evict_ready;
  assign w_ev_coal_vec = w_evict_fire ? w_ev_hit : '0;
  assign w_push        = w_evict_fire && !(|w_ev_hit);
  assign w_upd_hit     = bus.snoop_busupd ? w_sn_hit : '0;
  assign w_mem_write   = (r_state == WRITE);

  // A write that lands on the head in the grant cycle makes the bus copy stale,
  // so the head stays queued and goes out again with the new data.
  assign w_pop = w_mem_write && bus.bus_grant &&
                 !w_ev_coal_vec[r_head] && !w_upd_hit[r_head];

  assign w_count_next = r_count + CNTW'(w_push) - CNTW'(w_pop);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (r_count != '0) w_state_next = WRITE;
      WRITE:   if (w_pop && (w_count_next == '0)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_entries <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_state   <= IDLE;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop && (r_head == PTRW'(i))) r_entries[i].valid <= 1'b0;
        // Later assignment wins: evict data overrides a same-cycle BusUpd.
        if (w_upd_hit[i])     r_entries[i].data <= bus.snoop_data;
        if (w_ev_coal_vec[i]) r_entries[i].data <= bus.evict_data;
        if (w_push && (r_tail == PTRW'(i))) begin
          r_entries[i] <= '{valid: 1'b1,
                            index: bus.evict_index,
                            tag:   bus.evict_tag,
                            data:  bus.evict_data};
        end
      end
    end
  end

  assign bus.evict_ready  = w_evict_ready;
  assign bus.mem_write    = w_mem_write;
  assign bus.mem_index    = w_mem_write ? w_head.index : '0;
  assign bus.mem_tag      = w_mem_write ? w_head.tag   : '0;
  assign bus.mem_data     = w_mem_write ? w_head.data  : '0;
  assign bus.lookup_hit   = |w_lk_hit;
  assign bus.lookup_data  = w_lk_data;
  assign bus.snoop_shared = (bus.snoop_busrd || bus.snoop_busupd) && (|w_sn_hit);
  assign bus.snoop_flush  = (bus.snoop_busrd && (|w_sn_hit)) ? w_sn_data : '0;

  // Evict-side data is only needed as a hit indicator; fold it in so nothing dangles.
  logic w_ev_data_unused;
  assign w_ev_data_unused = ^w_ev_data;

endmodule

// File: tb/tb_writeback_buffer.sv
`timescale 1ns/1ps
module tb_writeback_buffer;
  import writeback_buffer_pkg::*;

  localparam int D = WB_DEPTH;

  typedef struct {
    logic [7:0]  idx;
    logic [5:0]  tag;
    logic [31:0] data;
  } blk_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  writeback_buffer_if bus();

  writeback_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_writes = 0;
  blk_t model_q[$];
  bit   model_drain = 1'b0;
  blk_t sb[$];
  blk_t mon_e;
  logic [31:0] mem_img [bit [13:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find(input logic [7:0] i, input logic [5:0] t);
    foreach (model_q[k]) if (model_q[k].idx == i && model_q[k].tag == t) return k;
    return -1;
  endfunction

  function automatic logic [31:0] mem_at(input logic [7:0] i, input logic [5:0] t);
    bit [13:0] k;
    k = {i, t};
    return mem_img.exists(k) ? mem_img[k] : 32'h0;
  endfunction

  // Monitor: every completed bus write must match the next expected write.
  always @(negedge clock) begin
    if (bus.mem_write === 1'b1 && bus.bus_grant === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_index", 64'(bus.mem_index), 64'(mon_e.idx));
        check("wr_tag",   64'(bus.mem_tag),   64'(mon_e.tag));
        check("wr_data",  64'(bus.mem_data),  64'(mon_e.data));
      end
      mem_img[{bus.mem_index, bus.mem_tag}] = bus.mem_data;
      n_writes++;
    end
  end

  // One clock cycle: drive, check combinational outputs against the model,
  // queue any expected write, then advance the model across the edge.
  task automatic step(input logic rst, input logic ev, input logic [7:0] ei, input logic [5:0] et,
                      input logic [31:0] ed, input logic gr, input logic rd, input logic up,
                      input logic [7:0] si, input logic [5:0] st, input logic [31:0] sd,
                      input logic [7:0] li, input logic [5:0] lt);
    int ep, sp, lp;
    bit rdy, fire, wr, sup, was_busy;
    reset            = rst;
    bus.evict_valid  = ev;
    bus.evict_index  = ei;
    bus.evict_tag    = et;
    bus.evict_data   = ed;
    bus.bus_grant    = gr & !rst;
    bus.snoop_busrd  = rd;
    bus.snoop_busupd = up;
    bus.snoop_index  = si;
    bus.snoop_tag    = st;
    bus.snoop_data   = sd;
    bus.lookup_index = li;
    bus.lookup_tag   = lt;
    #1;
    rdy = !rst && (model_q.size() < D);
    ep  = find(ei, et);
    sp  = find(si, st);
    lp  = find(li, lt);
    check("evict_ready",  64'(bus.evict_ready),  64'(rdy));
    check("mem_write",    64'(bus.mem_write),    64'(model_drain));
    check("lookup_hit",   64'(bus.lookup_hit),   64'(lp >= 0));
    check("lookup_data",  64'(bus.lookup_data),  (lp >= 0) ? 64'(model_q[lp].data) : 64'd0);
    check("snoop_shared", 64'(bus.snoop_shared), 64'((rd || up) && sp >= 0));
    check("snoop_flush",  64'(bus.snoop_flush),  (rd && sp >= 0) ? 64'(model_q[sp].data) : 64'd0);
    fire = ev && rdy;
    wr   = model_drain && gr && !rst;
    if (wr) sb.push_back(model_q[0]);
    sup = wr && ((fire && ep == 0) || (up && sp == 0));
    @(posedge clock);
    was_busy = model_q.size() > 0;
    if (!rst) begin
      if (up && sp >= 0)   model_q[sp].data = sd;
      if (fire && ep >= 0) model_q[ep].data = ed;
      if (wr && !sup)      void'(model_q.pop_front());
      if (fire && ep < 0)  model_q.push_back('{ei, et, ed});
      model_drain = model_drain ? (model_q.size() > 0) : was_busy;
    end else begin
      model_q.delete();
      model_drain = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic gr);
    step(1'b0, 1'b0, 8'd0, 6'd0, 32'd0, gr, 1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 8'd0, 6'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 8'd0, 6'd0);
  endtask

  task automatic evict(input logic [7:0] i, input logic [5:0] t, input logic [31:0] d, input logic gr);
    step(1'b0, 1'b1, i, t, d, gr, 1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 8'd0, 6'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((model_q.size() > 0 || model_drain) && n < 40) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", 64'(n >= 40), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  int w0;

  initial begin
    bus.evict_valid = 0; bus.evict_index = 0; bus.evict_tag = 0; bus.evict_data = 0;
    bus.bus_grant = 0; bus.snoop_busrd = 0; bus.snoop_busupd = 0; bus.snoop_index = 0;
    bus.snoop_tag = 0; bus.snoop_data = 0; bus.lookup_index = 0; bus.lookup_tag = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset state and single evict with grant held high.
    do_reset();
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    w0 = n_writes;
    evict(8'd5, 6'd1, 32'habcdef12, 1'b1);
    idle(1'b1);
    drain();
    check("single_writes", 64'(n_writes - w0), 64'd1);
    check("single_mem", 64'(mem_at(8'd5, 6'd1)), 64'habcdef12);

    // Fill to capacity with grant low, then drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) evict(8'(10 + k), 6'(k), 32'h1000_0000 + 32'(k), 1'b0);
    check("full_ready", 64'(bus.evict_ready), 64'd0);
    idle(1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);
    drain();

    // Coalescing before grant yields one write with the newest data.
    do_reset();
    w0 = n_writes;
    evict(8'd5, 6'd1, 32'h11111111, 1'b0);
    evict(8'd5, 6'd1, 32'h22222222, 1'b0);
    idle(1'b0);
    drain();
    check("coal_writes", 64'(n_writes - w0), 64'd1);
    check("coal_mem", 64'(mem_at(8'd5, 6'd1)), 64'h22222222);

    // BusUpd on the grant edge of the head: pop suppressed, rewritten.
    do_reset();
    w0 = n_writes;
    evict(8'd5, 6'd1, 32'haaaa5555, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b1, 8'd5, 6'd1, 32'hdeadbeef, 8'd0, 6'd0);
    drain();
    check("upd_writes", 64'(n_writes - w0), 64'd2);
    check("upd_mem", 64'(mem_at(8'd5, 6'd1)), 64'hdeadbeef);

    // BusRd and lookup hit / miss.
    do_reset();
    evict(8'd5, 6'd1, 32'hcafef00d, 1'b0);
    step(1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd5, 6'd1, 32'd0, 8'd5, 6'd1);
    check("busrd_flush", 64'(bus.snoop_flush), 64'hcafef00d);
    step(1'b0, 1'b0, 8'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd6, 6'd1, 32'd0, 8'd6, 6'd1);
    drain();

    // Reset mid-drain with three entries.
    for (int k = 0; k < 3; k++) evict(8'(20 + k), 6'(k), 32'h3000_0000 + 32'(k), 1'b0);
    idle(1'b0);
    do_reset();
    check("rst_drain_mem_write", 64'(bus.mem_write), 64'd0);
    idle(1'b1);
    check("rst_drain_ready", 64'(bus.evict_ready), 64'd1);

    // Randomised traffic over a small address space to provoke hits.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 6'($urandom_range(0, 1)), $urandom(),
           1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
           8'($urandom_range(0, 3)), 6'($urandom_range(0, 1)), $urandom(),
           8'($urandom_range(0, 3)), 6'($urandom_range(0, 1)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
